// File: rtl/axi_common_types_pkg.sv
// Shared AXI payload types for the m4s7 master-side write path.
// Payloads travel as flat vectors on module ports and are built or decoded through these structs.
package axi_common_types_pkg;

   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_LEN_WIDTH  = 8;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_USER_WIDTH = 1;

   typedef logic [AXI_LEN_WIDTH-1:0] axi_len_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      axi_len_t                  len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      lock;
      logic [3:0]                cache;
      logic [2:0]                prot;
      logic [3:0]                qos;
      logic [3:0]                region;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_aw_pl_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0]   data;
      logic [AXI_DATA_WIDTH/8-1:0] strb;
      logic                        last;
      logic [AXI_USER_WIDTH-1:0]   user;
   } axi_w_pl_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      axi_resp_t                 resp;
      logic [AXI_USER_WIDTH-1:0] user;
   } axi_b_pl_t;

   localparam int AW_PL_W = $bits(axi_aw_pl_t);
   localparam int W_PL_W  = $bits(axi_w_pl_t);
   localparam int B_PL_W  = $bits(axi_b_pl_t);

   // Bit positions of the only fields the tracker decodes; must follow the struct field order above.
   localparam int AW_LEN_LSB = 3 + 2 + 1 + 4 + 3 + 4 + 4 + AXI_USER_WIDTH;
   localparam int W_LAST_BIT = AXI_USER_WIDTH;

endpackage

// File: rtl/axi_skid_buf.sv
// Generic 2-entry valid/ready register slice: full throughput, registered ready, no comb paths.
// A beat transfers on any edge where valid && ready; valid must hold with stable data until then.
module axi_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   logic [WIDTH-1:0] slot [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       cnt;
   logic [1:0]       cnt_nxt;
   logic             push;
   logic             pop;

   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;
   assign m_valid = (cnt != 2'd0);
   assign m_data  = slot[rd_ptr];

   always_comb begin
      cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
   end

   // Ready is computed from the next occupancy so it never depends on m_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= 2'd0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         s_ready <= 1'b0;
         slot[0] <= '0;
         slot[1] <= '0;
      end else begin
         cnt     <= cnt_nxt;
         s_ready <= (cnt_nxt != 2'd2);
         if (push) begin
            slot[wr_ptr] <= s_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

endmodule

// File: rtl/axi_m_wr_tracker.sv
// Master-side write tracker: AW register slice, W gated on AW acceptance with WLAST checking,
// B pass-through used to bound outstanding writes.
module axi_m_wr_tracker
   import axi_common_types_pkg::*;
#(
   parameter int  MAX_OUTS = 4,
   localparam int CNT_W    = $clog2(MAX_OUTS + 1)
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic               s_awvalid,
   output logic               s_awready,
   input  logic [AW_PL_W-1:0] s_aw,
   input  logic               s_wvalid,
   output logic               s_wready,
   input  logic [W_PL_W-1:0]  s_w,
   output logic               s_bvalid,
   input  logic               s_bready,
   output logic [B_PL_W-1:0]  s_b,
   output logic               m_awvalid,
   input  logic               m_awready,
   output logic [AW_PL_W-1:0] m_aw,
   output logic               m_wvalid,
   input  logic               m_wready,
   output logic [W_PL_W-1:0]  m_w,
   input  logic               m_bvalid,
   output logic               m_bready,
   input  logic [B_PL_W-1:0]  m_b,
   output logic [CNT_W-1:0]   outs_cnt,
   output logic               err_wlast,
   output logic               err_bunexp
);

   localparam int               PTR_W   = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);
   localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(MAX_OUTS - 1);

   logic             space_q;
   logic             skid_ready;
   logic             aw_hs;
   logic             w_hs;
   logic             b_dec;
   logic             pop;
   logic             exp_last;
   logic             fifo_nempty;
   logic [CNT_W-1:0] outs_nxt;
   logic [CNT_W-1:0] fifo_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   axi_len_t         beat_cnt;
   axi_len_t         len_mem [MAX_OUTS];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_TOP) ? '0 : p + 1'b1;
   endfunction

   assign s_awready = skid_ready && space_q;
   assign aw_hs     = s_awvalid && s_awready;

   axi_skid_buf #(
      .WIDTH (AW_PL_W)
   ) u_aw_skid (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .s_valid (s_awvalid && space_q),
      .s_ready (skid_ready),
      .s_data  (s_aw),
      .m_valid (m_awvalid),
      .m_ready (m_awready),
      .m_data  (m_aw)
   );

   // W may only move while the length of its burst is known locally.
   assign fifo_nempty = (fifo_cnt != '0);
   assign m_wvalid    = s_wvalid && fifo_nempty;
   assign s_wready    = m_wready && fifo_nempty;
   assign m_w         = s_w;
   assign w_hs        = s_wvalid && s_wready;
   assign exp_last    = (beat_cnt == len_mem[rd_ptr]);
   assign pop         = w_hs && exp_last;

   assign s_bvalid = m_bvalid;
   assign s_b      = m_b;
   assign m_bready = s_bready;
   assign b_dec    = m_bvalid && s_bready && (outs_cnt != '0);

   always_comb begin
      outs_nxt = outs_cnt;
      if (aw_hs && !b_dec) begin
         outs_nxt = outs_cnt + 1'b1;
      end else if (!aw_hs && b_dec) begin
         outs_nxt = outs_cnt - 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         outs_cnt   <= '0;
         space_q    <= 1'b0;
         fifo_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         beat_cnt   <= '0;
         err_wlast  <= 1'b0;
         err_bunexp <= 1'b0;
      end else begin
         outs_cnt   <= outs_nxt;
         space_q    <= (outs_nxt < MAX_CNT);
         fifo_cnt   <= fifo_cnt + CNT_W'(aw_hs) - CNT_W'(pop);
         err_wlast  <= w_hs && (s_w[W_LAST_BIT] != exp_last);
         err_bunexp <= m_bvalid && s_bready && (outs_cnt == '0);
         if (aw_hs) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         // The beat count alone closes a burst; a wrong LAST is only flagged.
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            beat_cnt <= '0;
         end else if (w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (aw_hs) begin
         len_mem[wr_ptr] <= s_aw[AW_LEN_LSB +: AXI_LEN_WIDTH];
      end
   end

endmodule

// File: tb/tb_axi_m_wr_tracker.sv
// Directed bench for axi_m_wr_tracker: AW slice, W gating/WLAST checks, B bounding, reset.
`timescale 1ns/1ps
module tb_axi_m_wr_tracker;
   import axi_common_types_pkg::*;

   localparam int MAX_OUTS = 4;
   localparam int CNT_W    = $clog2(MAX_OUTS + 1);

   logic               clk;
   logic               rst_n;
   logic               s_awvalid;
   logic               s_awready;
   logic [AW_PL_W-1:0] s_aw;
   logic               s_wvalid;
   logic               s_wready;
   logic [W_PL_W-1:0]  s_w;
   logic               s_bvalid;
   logic               s_bready;
   logic [B_PL_W-1:0]  s_b;
   logic               m_awvalid;
   logic               m_awready;
   logic [AW_PL_W-1:0] m_aw;
   logic               m_wvalid;
   logic               m_wready;
   logic [W_PL_W-1:0]  m_w;
   logic               m_bvalid;
   logic               m_bready;
   logic [B_PL_W-1:0]  m_b;
   logic [CNT_W-1:0]   outs_cnt;
   logic               err_wlast;
   logic               err_bunexp;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   axi_m_wr_tracker #(
      .MAX_OUTS (MAX_OUTS)
   ) dut (
      .ACLK       (clk),
      .ARESETn    (rst_n),
      .s_awvalid  (s_awvalid),
      .s_awready  (s_awready),
      .s_aw       (s_aw),
      .s_wvalid   (s_wvalid),
      .s_wready   (s_wready),
      .s_w        (s_w),
      .s_bvalid   (s_bvalid),
      .s_bready   (s_bready),
      .s_b        (s_b),
      .m_awvalid  (m_awvalid),
      .m_awready  (m_awready),
      .m_aw       (m_aw),
      .m_wvalid   (m_wvalid),
      .m_wready   (m_wready),
      .m_w        (m_w),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .m_b        (m_b),
      .outs_cnt   (outs_cnt),
      .err_wlast  (err_wlast),
      .err_bunexp (err_bunexp)
   );

   function automatic logic [AW_PL_W-1:0] mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                                 input logic [7:0] len);
      axi_aw_pl_t a;
      a       = '0;
      a.id    = id;
      a.addr  = addr;
      a.len   = len;
      a.size  = 3'd2;
      a.burst = 2'b01;
      return a;
   endfunction

   function automatic logic [W_PL_W-1:0] mk_w(input logic [31:0] data, input logic last);
      axi_w_pl_t w;
      w      = '0;
      w.data = data;
      w.strb = 4'hf;
      w.last = last;
      return w;
   endfunction

   function automatic logic [B_PL_W-1:0] mk_b(input logic [3:0] id, input axi_resp_t resp);
      axi_b_pl_t b;
      b      = '0;
      b.id   = id;
      b.resp = resp;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW_PL_W-1:0] aw_a, aw_b, aw_c, aw_d, aw_e;
      logic [W_PL_W-1:0]  wb;
      logic [B_PL_W-1:0]  bb;
      logic [3:0]         lasts;
      logic [3:0]         exp_err;

      rst_n     = 1'b0;
      s_awvalid = 1'b0;
      s_aw      = '0;
      s_wvalid  = 1'b0;
      s_w       = '0;
      s_bready  = 1'b0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_b       = '0;
      #1;
      chk("rst_m_awvalid", m_awvalid, 1'b0);
      chk("rst_s_awready", s_awready, 1'b0);
      chk("rst_outs_cnt", outs_cnt, 0);
      chk("rst_m_wvalid", m_wvalid, 1'b0);
      chk("rst_err_wlast", err_wlast, 1'b0);
      chk("rst_err_bunexp", err_bunexp, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", s_awready, 1'b1);

      // 1: single LEN=3 write
      aw_a      = mk_aw(4'd2, 32'h1000, 8'd3);
      s_awvalid = 1'b1;
      s_aw      = aw_a;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      #1;
      chk("t1_awvalid_pre", m_awvalid, 1'b0);
      @(negedge clk);
      s_awvalid = 1'b0;
      #1;
      chk("t1_m_awvalid", m_awvalid, 1'b1);
      chk("t1_m_aw", m_aw, aw_a);
      chk("t1_outs_1", outs_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         wb       = mk_w(32'ha0 + i, (i == 3));
         s_wvalid = 1'b1;
         s_w      = wb;
         #1;
         chk("t1_m_wvalid", m_wvalid, 1'b1);
         chk("t1_m_w", m_w, wb);
         @(negedge clk);
         chk("t1_err_wlast", err_wlast, 1'b0);
      end
      s_w = mk_w(32'hdead, 1'b1);
      #1;
      chk("t1_w_gated", m_wvalid, 1'b0);
      chk("t1_wready_gated", s_wready, 1'b0);
      s_wvalid = 1'b0;
      bb       = mk_b(4'd2, OKAY);
      m_bvalid = 1'b1;
      m_b      = bb;
      s_bready = 1'b1;
      #1;
      chk("t1_s_bvalid", s_bvalid, 1'b1);
      chk("t1_s_b", s_b, bb);
      chk("t1_m_bready", m_bready, 1'b1);
      @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      #1;
      chk("t1_outs_0", outs_cnt, 0);
      chk("t1_err_bunexp", err_bunexp, 1'b0);

      // 2: back-pressure fills the slice, then drains without bubbles
      aw_a      = mk_aw(4'd1, 32'h2000, 8'd0);
      aw_b      = mk_aw(4'd3, 32'h2100, 8'd0);
      aw_c      = mk_aw(4'd4, 32'h2200, 8'd0);
      m_awready = 1'b0;
      s_awvalid = 1'b1;
      s_aw      = aw_a;
      #1;
      chk("t2_rdy_a", s_awready, 1'b1);
      @(negedge clk);
      s_aw = aw_b;
      #1;
      chk("t2_rdy_b", s_awready, 1'b1);
      @(negedge clk);
      s_aw = aw_c;
      #1;
      chk("t2_full", s_awready, 1'b0);
      chk("t2_head_a", m_aw, aw_a);
      @(negedge clk);
      chk("t2_still_full", s_awready, 1'b0);
      chk("t2_hold_a", m_aw, aw_a);
      m_awready = 1'b1;
      @(negedge clk);
      chk("t2_out_b_valid", m_awvalid, 1'b1);
      chk("t2_out_b", m_aw, aw_b);
      chk("t2_rdy_c", s_awready, 1'b1);
      @(negedge clk);
      s_awvalid = 1'b0;
      chk("t2_out_c_valid", m_awvalid, 1'b1);
      chk("t2_out_c", m_aw, aw_c);
      @(negedge clk);
      chk("t2_drained", m_awvalid, 1'b0);
      chk("t2_outs_3", outs_cnt, 3);

      // 3: outstanding limit, B and new AW in the same cycle
      aw_d      = mk_aw(4'd5, 32'h3000, 8'd0);
      aw_e      = mk_aw(4'd6, 32'h3100, 8'd0);
      s_awvalid = 1'b1;
      s_aw      = aw_d;
      #1;
      chk("t3_rdy_d", s_awready, 1'b1);
      @(negedge clk);
      s_aw = aw_e;
      #1;
      chk("t3_limit_rdy", s_awready, 1'b0);
      chk("t3_outs_4", outs_cnt, 4);
      s_wvalid = 1'b1;
      s_w      = mk_w(32'h1, 1'b1);
      @(negedge clk);
      s_wvalid = 1'b0;
      chk("t3_err_wlast", err_wlast, 1'b0);
      chk("t3_limit_hold", s_awready, 1'b0);
      m_bvalid = 1'b1;
      m_b      = mk_b(4'd1, OKAY);
      s_bready = 1'b1;
      @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      #1;
      chk("t3_rdy_after_b", s_awready, 1'b1);
      chk("t3_no_bunexp", err_bunexp, 1'b0);
      @(negedge clk);
      s_awvalid = 1'b0;
      #1;
      chk("t3_outs_back_4", outs_cnt, 4);
      chk("t3_limit_again", s_awready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         s_wvalid = 1'b1;
         s_w      = mk_w(32'h10 + i, 1'b1);
         @(negedge clk);
         chk("t3_drain_wlast", err_wlast, 1'b0);
      end
      s_wvalid = 1'b0;
      m_bvalid = 1'b1;
      s_bready = 1'b1;
      repeat (4) @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      #1;
      chk("t3_outs_0", outs_cnt, 0);
      chk("t3_drain_bunexp", err_bunexp, 1'b0);

      // 4: WLAST early on beat 2 and missing on beat 4
      s_awvalid = 1'b1;
      s_aw      = mk_aw(4'd7, 32'h4000, 8'd3);
      @(negedge clk);
      s_awvalid = 1'b0;
      lasts     = 4'b0010;
      exp_err   = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         s_wvalid = 1'b1;
         s_w      = mk_w(32'h40 + i, lasts[i]);
         @(negedge clk);
         chk($sformatf("t4_err_wlast_beat%0d", i + 1), err_wlast, exp_err[i]);
      end
      s_w = mk_w(32'h99, 1'b1);
      #1;
      chk("t4_fifo_popped", m_wvalid, 1'b0);
      s_wvalid = 1'b0;
      m_bvalid = 1'b1;
      s_bready = 1'b1;
      @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      chk("t4_outs_0", outs_cnt, 0);

      // 5: unexpected B
      bb       = mk_b(4'd9, SLVERR);
      m_bvalid = 1'b1;
      m_b      = bb;
      s_bready = 1'b1;
      #1;
      chk("t5_b_fwd_valid", s_bvalid, 1'b1);
      chk("t5_b_fwd", s_b, bb);
      @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      chk("t5_bunexp", err_bunexp, 1'b1);
      chk("t5_outs_0", outs_cnt, 0);
      @(negedge clk);
      chk("t5_bunexp_pulse", err_bunexp, 1'b0);

      // 6: reset in the middle of a LEN=7 burst
      m_awready = 1'b0;
      s_awvalid = 1'b1;
      s_aw      = mk_aw(4'd8, 32'h5000, 8'd7);
      @(negedge clk);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b1;
      s_w       = mk_w(32'h60, 1'b0);
      @(negedge clk);
      chk("t6_beat1_err", err_wlast, 1'b0);
      s_w = mk_w(32'h61, 1'b0);
      #1;
      chk("t6_pre_awvalid", m_awvalid, 1'b1);
      chk("t6_pre_wvalid", m_wvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_awvalid", m_awvalid, 1'b0);
      chk("t6_rst_wvalid", m_wvalid, 1'b0);
      chk("t6_rst_outs", outs_cnt, 0);
      chk("t6_rst_awready", s_awready, 1'b0);
      s_wvalid  = 1'b0;
      m_awready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rdy_after_rst", s_awready, 1'b1);
      aw_a      = mk_aw(4'd3, 32'h6000, 8'd0);
      s_awvalid = 1'b1;
      s_aw      = aw_a;
      @(negedge clk);
      s_awvalid = 1'b0;
      chk("t6_m_aw", m_aw, aw_a);
      chk("t6_outs_1", outs_cnt, 1);
      s_wvalid = 1'b1;
      s_w      = mk_w(32'h70, 1'b1);
      #1;
      chk("t6_m_wvalid", m_wvalid, 1'b1);
      @(negedge clk);
      s_wvalid = 1'b0;
      chk("t6_err_wlast", err_wlast, 1'b0);
      m_bvalid = 1'b1;
      m_b      = mk_b(4'd3, OKAY);
      s_bready = 1'b1;
      @(negedge clk);
      m_bvalid = 1'b0;
      s_bready = 1'b0;
      chk("t6_outs_0", outs_cnt, 0);
      chk("t6_err_bunexp", err_bunexp, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
